// File: rtl/data_mem_responder.sv
// Handshaked RV32I data-memory responder: accepts one load/store, waits
// WAIT_CYCLES, performs the byte-lane steered access, then returns data or an error.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(WAIT_CYCLES);
    localparam logic [63:0]      SPAN_BYTES = 64'(DEPTH_WORDS) * 64'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem_q [0:DEPTH_WORDS-1];

    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             is_half, is_word;
    logic             misaligned, out_of_range, bad_f3, acc_err;
    logic             access, mem_we;
    logic [3:0]       be;
    logic [31:0]      wlane;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        logic signed [7:0]  s;
        logic signed [31:0] w;
        s = b;
        w = s;
        return w;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = h;
        w = s;
        return w;
    endfunction

    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'd0, b};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] h);
        return {16'd0, h};
    endfunction

    // Access decode, always evaluated on the captured request
    always_comb begin
        offset       = addr_q - BASE_ADDR;
        word_idx     = IDX_W'(offset >> 2);
        is_half      = (f3_q[1:0] == 2'b01);
        is_word      = (f3_q[1:0] == 2'b10);
        misaligned   = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
        out_of_range = (addr_q < BASE_ADDR) || ({32'd0, offset} >= SPAN_BYTES);
        if (we_q) begin
            bad_f3 = (f3_q > 3'd2);
        end else begin
            bad_f3 = (f3_q == 3'd3) || (f3_q == 3'd6) || (f3_q == 3'd7);
        end
        acc_err = misaligned || out_of_range || bad_f3;
    end

    assign access = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we = access && we_q && !acc_err && !reset;

    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        case (f3_q)
            3'd0: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            3'd1: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            3'd2: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
            default: begin
                be    = 4'b0000;
                wlane = wdata_q;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem_q[word_idx];
        byte_sel = rd_word[8*addr_q[1:0] +: 8];
        half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3_q)
            3'd0:    load_val = sext8(byte_sel);
            3'd1:    load_val = sext16(half_sel);
            3'd2:    load_val = rd_word;
            3'd4:    load_val = zext8(byte_sel);
            3'd5:    load_val = zext16(half_sel);
            default: load_val = 32'd0;
        endcase
    end

    // Backing array is never reset; writes are gated off by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? 32'd0 : load_val;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a byte-array reference model.
module tb_data_mem_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mbytes [0:255];

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic scramble_req();
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
    endtask

    task automatic wait_rsp(input string name);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            chk({name, " ready_low"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, LAT);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input int hold, input string name,
                       output logic err, output logic [31:0] rd);
        logic [31:0] rd0;
        logic        e0;
        @(negedge clk);
        chk({name, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
        wait_rsp(name);
        rd0 = rsp_rdata;
        e0  = rsp_err;
        for (int i = 0; i < hold; i++) begin
            scramble_req();
            @(posedge clk); #1;
            chk({name, " hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, " hold_rdata"}, rsp_rdata, rd0);
            chk({name, " hold_err"}, 32'(rsp_err), 32'(e0));
            chk({name, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, " valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({name, " ready_back"}, 32'(req_ready), 32'd1);
        err = e0;
        rd  = rd0;
    endtask

    // Reference: byte-addressed memory, sizes and extension straight from the ISA rules
    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, output logic err, output logic [31:0] rd);
        int     size;
        bit     sgn;
        bit     legal;
        longint v;
        size = 1; sgn = 0; legal = 1;
        if (we) begin
            legal = (f3 <= 3'd2);
            if (legal) size = 1 << f3;
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 0;
            endcase
        end
        err = !legal || ((addr % size) != 0) || (addr >= 32'd4096);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mbytes[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(mbytes[addr + i]) << (8 * i);
                if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
                rd = 32'(v);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        logic        e, me;
        logic [31:0] r, mr, rd0;
        logic        we;
        logic [31:0] addr, wd;
        logic [2:0]  f3;
        int          sel;

        vecs = '{
            '{"sw_beef",     1, 32'h10,   32'hDEADBEEF, 3'd2, 0, 32'h0},
            '{"lw_beef",     0, 32'h10,   32'h0,        3'd2, 0, 32'hDEADBEEF},
            '{"sw0_20",      1, 32'h20,   32'h0,        3'd2, 0, 32'h0},
            '{"sb_21",       1, 32'h21,   32'h80,       3'd0, 0, 32'h0},
            '{"lb_21",       0, 32'h21,   32'h0,        3'd0, 0, 32'hFFFFFF80},
            '{"lbu_21",      0, 32'h21,   32'h0,        3'd4, 0, 32'h00000080},
            '{"lw_20",       0, 32'h20,   32'h0,        3'd2, 0, 32'h00008000},
            '{"sw_30",       1, 32'h30,   32'h11223344, 3'd2, 0, 32'h0},
            '{"sh_32",       1, 32'h32,   32'h0000BEEF, 3'd1, 0, 32'h0},
            '{"lh_32",       0, 32'h32,   32'h0,        3'd1, 0, 32'hFFFFBEEF},
            '{"lhu_32",      0, 32'h32,   32'h0,        3'd5, 0, 32'h0000BEEF},
            '{"lw_30",       0, 32'h30,   32'h0,        3'd2, 0, 32'hBEEF3344},
            '{"sh_mis_31",   1, 32'h31,   32'h00001234, 3'd1, 1, 32'h0},
            '{"lw_30_again", 0, 32'h30,   32'h0,        3'd2, 0, 32'hBEEF3344},
            '{"lw_oor",      0, 32'h1000, 32'h0,        3'd2, 1, 32'h0},
            '{"ld_f3_3",     0, 32'h30,   32'h0,        3'd3, 1, 32'h0},
            '{"st_f3_4",     1, 32'h30,   32'h55555555, 3'd4, 1, 32'h0},
            '{"lw_mis_32",   0, 32'h32,   32'h0,        3'd2, 1, 32'h0},
            '{"lw_30_kept",  0, 32'h30,   32'h0,        3'd2, 0, 32'hBEEF3344},
            '{"lb_33",       0, 32'h33,   32'h0,        3'd0, 0, 32'hFFFFFFBE},
            '{"sw0_40",      1, 32'h40,   32'h0,        3'd2, 0, 32'h0},
            '{"sw0_44",      1, 32'h44,   32'h0,        3'd2, 0, 32'h0},
            '{"lw_40",       0, 32'h40,   32'h0,        3'd2, 0, 32'h0}
        };

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, i % 3, vecs[i].name, e, r);
            chk({vecs[i].name, " err"}, 32'(e), 32'(vecs[i].exp_err));
            chk({vecs[i].name, " rdata"}, r, vecs[i].exp_rdata);
        end

        // Backpressure with a second request held pending
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2;
        @(posedge clk); #1;
        chk("bp accept1", 32'(req_ready), 32'd0);
        req_addr = 32'h30;
        wait_rsp("bp first");
        rd0 = rsp_rdata;
        chk("bp first rdata", rd0, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp stall valid", 32'(rsp_valid), 32'd1);
            chk("bp stall rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp stall err", 32'(rsp_err), 32'd0);
            chk("bp stall ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp hs valid", 32'(rsp_valid), 32'd0);
        chk("bp hs ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp accept2", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_rsp("bp second");
        chk("bp second rdata", rsp_rdata, 32'hBEEF3344);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset while the store is still counting
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstw valid", 32'(rsp_valid), 32'd0);
        chk("rstw ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("rstw quiet", 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, 32'h40, 32'h0, 3'd2, 0, "rstw lw40", e, r);
        chk("rstw lw40 rdata", r, 32'h0);

        // Reset coinciding with the access edge must also block the write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h12345678; req_funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rsta valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h44, 32'h0, 3'd2, 0, "rsta lw44", e, r);
        chk("rsta lw44 rdata", r, 32'h0);

        // Reset in RESP discards the response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp("rstr");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstr valid", 32'(rsp_valid), 32'd0);
        chk("rstr ready", 32'(req_ready), 32'd1);

        // Randomized traffic against the reference model
        for (int w = 0; w < 64; w++) begin
            txn(1'b1, 32'(w * 4), 32'h0, 3'd2, 0, "init", e, r);
            model_txn(1'b1, 32'(w * 4), 32'h0, 3'd2, me, mr);
        end
        for (int n = 0; n < 200; n++) begin
            we  = 1'($urandom);
            f3  = 3'($urandom_range(0, 7));
            wd  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'h1000 + $urandom_range(0, 255);
            else if (sel == 1) addr = 32'hF000_0000 | $urandom;
            else               addr = $urandom_range(0, 255);
            model_txn(we, addr, wd, f3, me, mr);
            txn(we, addr, wd, f3, $urandom_range(0, 2), "rnd", e, r);
            chk("rnd err", 32'(e), 32'(me));
            chk("rnd rdata", r, mr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
